// File: rtl/inv_shift_rows.sv
// inv_shift_rows: registered AES InvShiftRows byte permutation behind 1 or 2 valid/ready stages.
// Optional macro FWD_SHIFT_EN adds a fwd input that selects forward ShiftRows per transfer.
module inv_shift_rows #(
  parameter int LATENCY = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state,
`ifdef FWD_SHIFT_EN
  input  logic         fwd,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] newstate
);
  // Handshake: a state crosses a stage boundary on a rising edge when the
  // sender's valid and the receiver's ready are both high. A stage is ready
  // when empty or when its own contents leave on the same edge; valid never
  // depends on ready, and a presented state holds stable until taken.

  if (LATENCY != 1 && LATENCY != 2) begin : g_bad_latency
    $error("inv_shift_rows: LATENCY must be 1 or 2");
  end

  // Byte k sits at row k%4, column k/4; byte 0 is the MSB byte.
  function automatic logic [127:0] permute(input logic [127:0] s, input logic fwd_sel);
    logic [127:0] o;
    int r;
    int c;
    int src_c;
    o = '0;
    for (int k = 0; k < 16; k++) begin
      r = k % 4;
      c = k / 4;
      src_c = fwd_sel ? (c + r) % 4 : (c - r + 4) % 4;
      o[127-8*k -: 8] = s[127-8*(src_c*4+r) -: 8];
    end
    return o;
  endfunction

  logic fwd_sel;
`ifdef FWD_SHIFT_EN
  assign fwd_sel = fwd;
`else
  assign fwd_sel = 1'b0;
`endif

  logic [127:0] perm_state;
  assign perm_state = permute(state, fwd_sel);

  logic         s0_valid_q;
  logic         s0_valid_d;
  logic [127:0] s0_data_q;
  logic [127:0] s0_data_d;
  logic         s0_rdy;
  logic         s0_next_rdy;

  assign s0_rdy   = !s0_valid_q || s0_next_rdy;
  assign in_ready = s0_rdy;

  always_comb begin
    s0_valid_d = s0_valid_q;
    s0_data_d  = s0_data_q;
    if (s0_rdy) begin
      s0_valid_d = in_valid;
      if (in_valid) s0_data_d = perm_state;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_valid_q <= 1'b0;
      s0_data_q  <= '0;
    end else begin
      s0_valid_q <= s0_valid_d;
      s0_data_q  <= s0_data_d;
    end
  end

  if (LATENCY == 2) begin : g_two
    logic         s1_valid_q;
    logic         s1_valid_d;
    logic [127:0] s1_data_q;
    logic [127:0] s1_data_d;
    logic         s1_rdy;

    assign s1_rdy      = !s1_valid_q || out_ready;
    assign s0_next_rdy = s1_rdy;

    always_comb begin
      s1_valid_d = s1_valid_q;
      s1_data_d  = s1_data_q;
      if (s1_rdy) begin
        s1_valid_d = s0_valid_q;
        if (s0_valid_q) s1_data_d = s0_data_q;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_valid_q <= 1'b0;
        s1_data_q  <= '0;
      end else begin
        s1_valid_q <= s1_valid_d;
        s1_data_q  <= s1_data_d;
      end
    end

    assign out_valid = s1_valid_q;
    assign newstate  = s1_data_q;
  end else begin : g_one
    assign s0_next_rdy = out_ready;
    assign out_valid   = s0_valid_q;
    assign newstate    = s0_data_q;
  end

endmodule

// File: tb/tb_inv_shift_rows.sv
// Directed bench for inv_shift_rows: one LATENCY=1 and one LATENCY=2 instance.
// The fwd round-trip section is compiled only when FWD_SHIFT_EN is defined.
module tb_inv_shift_rows;

  localparam logic [127:0] SPOT     = 128'h00010203_04050708_090A0080_C0E0F0F9;
  localparam logic [127:0] SPOT_EXP = 128'h00E00008_0401F080_090502F9_C00A0703;
  localparam logic [127:0] IDENT    = 128'h00112233_00112233_00112233_00112233;

  // out byte k takes in byte MAP[k]
  localparam int MAP [16] = '{0, 13, 10, 7, 4, 1, 14, 11, 8, 5, 2, 15, 12, 9, 6, 3};

  logic         clk;
  logic         rst_n;

  logic         in_valid1, in_ready1, out_valid1, out_ready1;
  logic [127:0] state1, newstate1;
  logic         in_valid2, in_ready2, out_valid2, out_ready2;
  logic [127:0] state2, newstate2;
`ifdef FWD_SHIFT_EN
  logic         fwd1, fwd2;
`endif

  int n_vec = 0;
  int n_err = 0;
  logic [127:0] exp_q[$];

  inv_shift_rows #(.LATENCY(1)) dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid1),
    .in_ready (in_ready1),
    .state    (state1),
`ifdef FWD_SHIFT_EN
    .fwd      (fwd1),
`endif
    .out_valid(out_valid1),
    .out_ready(out_ready1),
    .newstate (newstate1)
  );

  inv_shift_rows #(.LATENCY(2)) dut2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid2),
    .in_ready (in_ready2),
    .state    (state2),
`ifdef FWD_SHIFT_EN
    .fwd      (fwd2),
`endif
    .out_valid(out_valid2),
    .out_ready(out_ready2),
    .newstate (newstate2)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] ref_inv(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int k = 0; k < 16; k++) o[127-8*k -: 8] = s[127-8*MAP[k] -: 8];
    return o;
  endfunction

  function automatic logic [127:0] stream_vec(input int i);
    logic [127:0] v;
    v = '0;
    for (int k = 0; k < 16; k++) v[127-8*k -: 8] = 8'((16*i + k) & 255);
    return v;
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // advance one clock; return just after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid1 = 1'b0; out_ready1 = 1'b1; state1 = '0;
    in_valid2 = 1'b0; out_ready2 = 1'b1; state2 = '0;
`ifdef FWD_SHIFT_EN
    fwd1 = 1'b0; fwd2 = 1'b0;
`endif
    #3;
    check("reset_out_valid1", 128'(out_valid1), 128'(0));
    check("reset_newstate1", newstate1, '0);
    check("reset_out_valid2", 128'(out_valid2), 128'(0));
    step(); step();
    #2 rst_n = 1'b1;
    step();
    check("post_reset_in_ready1", 128'(in_ready1), 128'(1));
    check("post_reset_in_ready2", 128'(in_ready2), 128'(1));

    // spot vector, LATENCY=1
    in_valid1 = 1'b1; state1 = SPOT;
    step();
    in_valid1 = 1'b0; state1 = '0;
    check("spot_valid", 128'(out_valid1), 128'(1));
    check("spot_data", newstate1, SPOT_EXP);
    step();
    check("spot_drained", 128'(out_valid1), 128'(0));

    // identity rows
    in_valid1 = 1'b1; state1 = IDENT;
    step();
    in_valid1 = 1'b0;
    check("ident_data", newstate1, IDENT);
    step();

    // backpressure, LATENCY=1; source holds IDENT while blocked
    out_ready1 = 1'b0;
    in_valid1 = 1'b1; state1 = SPOT;
    step();
    state1 = IDENT;
    for (int c = 0; c < 5; c++) begin
      check("bp_valid", 128'(out_valid1), 128'(1));
      check("bp_data", newstate1, SPOT_EXP);
      check("bp_in_ready", 128'(in_ready1), 128'(0));
      step();
    end
    out_ready1 = 1'b1;
    #1;
    check("bp_release_in_ready", 128'(in_ready1), 128'(1));
    step();
    // drain and reload on the same edge
    check("reload_valid", 128'(out_valid1), 128'(1));
    check("reload_data", newstate1, IDENT);
    in_valid1 = 1'b0;
    step();
    check("reload_drained", 128'(out_valid1), 128'(0));
    check("reload_in_ready", 128'(in_ready1), 128'(1));

    // streaming, LATENCY=2
    for (int j = 0; j < 10; j++) begin
      if (j < 8) begin
        in_valid2 = 1'b1;
        state2 = stream_vec(j);
        check("stream_in_ready", 128'(in_ready2), 128'(1));
        if (in_ready2) exp_q.push_back(ref_inv(stream_vec(j)));
      end else begin
        in_valid2 = 1'b0;
      end
      step();
      if (j >= 1 && j <= 8) begin
        check("stream_valid", 128'(out_valid2), 128'(1));
        if (exp_q.size() > 0) check("stream_data", newstate2, exp_q.pop_front());
        else check("stream_queue_empty", 128'(1), 128'(0));
      end else begin
        check("stream_idle", 128'(out_valid2), 128'(0));
      end
    end
    check("stream_all_out", 128'(exp_q.size()), 128'(0));

    // backpressure, LATENCY=2: both stages fill, then in_ready drops
    out_ready2 = 1'b0;
    in_valid2 = 1'b1; state2 = stream_vec(3);
    step();
    state2 = stream_vec(5);
    check("bp2_in_ready_half", 128'(in_ready2), 128'(1));
    step();
    in_valid2 = 1'b0;
    check("bp2_valid", 128'(out_valid2), 128'(1));
    check("bp2_data_a", newstate2, ref_inv(stream_vec(3)));
    check("bp2_in_ready_full", 128'(in_ready2), 128'(0));
    step();
    check("bp2_hold", newstate2, ref_inv(stream_vec(3)));
    out_ready2 = 1'b1;
    step();
    check("bp2_data_b", newstate2, ref_inv(stream_vec(5)));
    step();
    check("bp2_drained", 128'(out_valid2), 128'(0));

    // asynchronous reset while holding a result
    out_ready1 = 1'b0;
    in_valid1 = 1'b1; state1 = SPOT;
    step();
    in_valid1 = 1'b0;
    check("pre_areset_valid", 128'(out_valid1), 128'(1));
    #2 rst_n = 1'b0;
    #1;
    check("areset_valid", 128'(out_valid1), 128'(0));
    check("areset_data", newstate1, '0);
    step();
    #2 rst_n = 1'b1;
    out_ready1 = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      check("no_stale_valid1", 128'(out_valid1), 128'(0));
      check("no_stale_valid2", 128'(out_valid2), 128'(0));
    end
    check("areset_in_ready", 128'(in_ready1), 128'(1));

`ifdef FWD_SHIFT_EN
    // forward ShiftRows undoes the inverse
    fwd1 = 1'b1; in_valid1 = 1'b1; state1 = SPOT_EXP;
    step();
    in_valid1 = 1'b0; fwd1 = 1'b0;
    check("fwd_roundtrip", newstate1, SPOT);
    in_valid1 = 1'b1; state1 = SPOT;
    step();
    in_valid1 = 1'b0;
    check("fwd0_inverse", newstate1, SPOT_EXP);
    step();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
